rx_detect_sequencer: RTL and testbench
======================================

Name: rx_detect_sequencer

Overview:
Per-link Detect.Quiet/Detect.Active sequencer. It drives the analog receiver-detect handshake on all lanes and applies the PCIe two-pass rule for partial detection. It produces the phy_layer_lane_detect vector and the detect-active flag consumed by the LTSSM controller's DETECT state. It sits between the PHY electrical receiver-detect circuit and the controller.

Parameters:
NUM_LANES, 1, lane count; width of every per-lane vector.
QUIET_CYCLES, 16, Detect.Quiet timeout in clk_i cycles (12 ms scaled).
RETRY_CYCLES, 16, wait between first and second detect pass (12 ms scaled).
DET_TIMEOUT_CYCLES, 8, max cycles to wait for rx_det_done_i before abandoning a pass.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  controller is in DETECT; low forces IDLE
rx_eidle_exit_i  in  NUM_LANES  per-lane electrical-idle exit seen; any bit ends Quiet early
rx_det_req_o  out  1  request one receiver-detect pass on all lanes
rx_det_done_i  in  1  pass complete; rx_det_result_i valid this cycle
rx_det_result_i  in  NUM_LANES  per-lane receiver present
detect_active_o  out  1  sequencer is in an active detect pass or retry wait
lane_detect_o  out  NUM_LANES  final detected-lane mask, held while lane_detect_valid_o
lane_detect_valid_o  out  1  final mask valid; held until enable_i drops

Behaviour:
- Reset (rst_ni low, async): state IDLE, all outputs 0, counters 0, pass-1 mask 0.
- States: IDLE, QUIET, ACT1, RETRY, ACT2, DONE. Encoding is det_st_e.
- IDLE: when enable_i=1, go to QUIET next cycle and load the timer with QUIET_CYCLES-1.
- QUIET: timer decrements each cycle. Go to ACT1 when the timer reaches 0 or |rx_eidle_exit_i, whichever comes first.
- ACT1/ACT2:
  - rx_det_req_o=1 from the first cycle in the state. It stays high until the cycle rx_det_done_i=1 is sampled, then deasserts the next cycle.
  - Timeout counter loads DET_TIMEOUT_CYCLES-1 on entry.
  - rx_det_done_i when not requesting is ignored.
- ACT1 on done:
  - result == 0: back to QUIET.
  - result == all-ones: store result, go to DONE.
  - otherwise (partial): store result as mask1, go to RETRY with the timer loaded RETRY_CYCLES-1.
- RETRY: wait until the timer reaches 0, then go to ACT2.
- ACT2 on done: final mask = mask1 & result.
  - Nonzero mask: go to DONE.
  - Zero mask: go to QUIET.
- Pass timeout: if the timeout counter reaches 0 without done, treat the result as all-zero, drop rx_det_req_o, and go to QUIET.
- DONE:
  - lane_detect_o = final mask and lane_detect_valid_o = 1, both registered and available the cycle after the done sample.
  - Both hold while enable_i=1.
- detect_active_o = 1 in ACT1, RETRY, ACT2 and DONE; 0 in IDLE and QUIET.
- enable_i=0 in any state: next cycle go to IDLE. All outputs and the mask clear; an in-flight req drops with no wait for done.
- Simultaneous events:
  - Done and timeout zero in the same cycle: done wins.
  - Eidle exit and quiet timer zero in the same cycle: single transition to ACT1.
- Latency: with enable_i rising at cycle 0, fully detected lanes and done returned 1 cycle after req give lane_detect_valid_o high by cycle QUIET_CYCLES+4 at most.
- Counter width: $clog2(max(QUIET_CYCLES, RETRY_CYCLES, DET_TIMEOUT_CYCLES)+1). Counters saturate at 0 and never wrap.

Decomposition:
- det_st_e enum goes in ltssm_pkg alongside ltssm_e.
- Timer default constants (scaled 12 ms) go in ltssm_pkg.
- One sub-module, ltssm_timer: loadable down-counter with load_i, value_i, expired_o. The sequencer instantiates it twice, once for quiet/retry and once for pass timeout.

Test Plan:
(NUM_LANES=4, QUIET_CYCLES=16, RETRY_CYCLES=16, DET_TIMEOUT_CYCLES=8)
1. Reset held low mid-ACT1 with req high -> rx_det_req_o, lane_detect_valid_o and detect_active_o all 0 immediately (async); after release the sequencer restarts from IDLE.
2. enable_i=1, no eidle exit, done after 2 cycles with result 4'b1111 -> req rises exactly 16 cycles after QUIET entry; lane_detect_o=4'b1111 and valid=1 the cycle after done.
3. Pass 1 result 4'b1011, pass 2 result 4'b0011 -> RETRY lasts 16 cycles; final lane_detect_o=4'b0011.
4. Pass 1 result 4'b0000 -> returns to QUIET and detect_active_o=0; rx_eidle_exit_i=4'b0100 then triggers ACT1 on the next cycle, before the timer expires.
5. rx_det_done_i never asserted -> req drops after 8 cycles and the state returns to QUIET. A stray done pulse while in QUIET has no effect.
6. enable_i dropped in DONE and in RETRY -> next cycle all outputs 0; re-enable restarts with a full QUIET period.

Source files
------------

// File: rtl/ltssm_pkg.sv
// Shared LTSSM types and default timer constants for the detect path.
package ltssm_pkg;

  // Top-level LTSSM states owned by the link controller.
  typedef enum logic [3:0] {
    LTSSM_DETECT,
    LTSSM_POLLING,
    LTSSM_CONFIG,
    LTSSM_L0,
    LTSSM_RECOVERY,
    LTSSM_DISABLED
  } ltssm_e;

  // Sub-states of the receiver-detect sequencer.
  typedef enum logic [2:0] {
    DET_IDLE,
    DET_QUIET,
    DET_ACT1,
    DET_RETRY,
    DET_ACT2,
    DET_DONE
  } det_st_e;

  // 12 ms intervals scaled down to a handful of clock cycles.
  localparam int QUIET_CYCLES_DEF       = 16;
  localparam int RETRY_CYCLES_DEF       = 16;
  localparam int DET_TIMEOUT_CYCLES_DEF = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ltssm_timer.sv
// Loadable down-counter that stops at zero; expired_o flags the zero state.
module ltssm_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count;

  // Load takes priority; otherwise count down and hold at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (load_i) begin
      count <= value_i;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired_o = (count == '0);

endmodule

// File: rtl/rx_detect_sequencer.sv
// Detect.Quiet / Detect.Active sequencer with the two-pass partial-detect rule.
module rx_detect_sequencer
  import ltssm_pkg::*;
#(
  parameter int NUM_LANES          = 1,
  parameter int QUIET_CYCLES       = QUIET_CYCLES_DEF,
  parameter int RETRY_CYCLES       = RETRY_CYCLES_DEF,
  parameter int DET_TIMEOUT_CYCLES = DET_TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic [NUM_LANES-1:0] rx_eidle_exit_i,
  output logic                 rx_det_req_o,
  input  logic                 rx_det_done_i,
  input  logic [NUM_LANES-1:0] rx_det_result_i,
  output logic                 detect_active_o,
  output logic [NUM_LANES-1:0] lane_detect_o,
  output logic                 lane_detect_valid_o
);

  localparam int CW = $clog2(max3(QUIET_CYCLES, RETRY_CYCLES, DET_TIMEOUT_CYCLES) + 1);
  localparam logic [NUM_LANES-1:0] ALL_LANES = {NUM_LANES{1'b1}};

  det_st_e              state;
  logic [NUM_LANES-1:0] mask1;
  logic [NUM_LANES-1:0] final_mask;

  logic          wait_load;
  logic [CW-1:0] wait_value;
  logic          wait_expired;
  logic          pass_load;
  logic [CW-1:0] pass_value;
  logic          pass_expired;

  logic in_pass;
  logic req_done;
  logic pass_timeout;
  logic enter_quiet;
  logic enter_retry;
  logic enter_act;

  // Transition events; shared by the FSM and the timer load strobes so the
  // timers hold their start value in the first cycle of the new state.
  always_comb begin
    in_pass      = (state == DET_ACT1) || (state == DET_ACT2);
    req_done     = rx_det_req_o && rx_det_done_i;
    pass_timeout = in_pass && rx_det_req_o && !rx_det_done_i && pass_expired;
    final_mask   = mask1 & rx_det_result_i;
    enter_quiet  = enable_i && ((state == DET_IDLE) ||
                   (state == DET_ACT1 && req_done && rx_det_result_i == '0) ||
                   (state == DET_ACT2 && req_done && final_mask == '0) ||
                   pass_timeout);
    enter_retry  = enable_i && (state == DET_ACT1) && req_done &&
                   (rx_det_result_i != '0) && (rx_det_result_i != ALL_LANES);
    enter_act    = enable_i &&
                   ((state == DET_QUIET && (wait_expired || (|rx_eidle_exit_i))) ||
                    (state == DET_RETRY && wait_expired));
  end

  // Quiet/retry timer and pass-timeout timer are cleared whenever disabled.
  always_comb begin
    wait_load  = !enable_i || enter_quiet || enter_retry;
    wait_value = !enable_i  ? '0 :
                 enter_quiet ? CW'(QUIET_CYCLES - 1) : CW'(RETRY_CYCLES - 1);
    pass_load  = !enable_i || enter_act;
    pass_value = enable_i ? CW'(DET_TIMEOUT_CYCLES - 1) : '0;
  end

  ltssm_timer #(.WIDTH(CW)) u_wait_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (wait_load),
    .value_i   (wait_value),
    .expired_o (wait_expired)
  );

  ltssm_timer #(.WIDTH(CW)) u_pass_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (pass_load),
    .value_i   (pass_value),
    .expired_o (pass_expired)
  );

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state               <= DET_IDLE;
      rx_det_req_o        <= 1'b0;
      detect_active_o     <= 1'b0;
      lane_detect_o       <= '0;
      lane_detect_valid_o <= 1'b0;
      mask1               <= '0;
    end else if (!enable_i) begin
      state               <= DET_IDLE;
      rx_det_req_o        <= 1'b0;
      detect_active_o     <= 1'b0;
      lane_detect_o       <= '0;
      lane_detect_valid_o <= 1'b0;
      mask1               <= '0;
    end else begin
      case (state)
        DET_IDLE: state <= DET_QUIET;
        DET_QUIET: begin
          if (enter_act) begin
            state           <= DET_ACT1;
            rx_det_req_o    <= 1'b1;
            detect_active_o <= 1'b1;
          end
        end
        DET_ACT1: begin
          if (req_done) begin
            rx_det_req_o <= 1'b0;
            if (rx_det_result_i == '0) begin
              state           <= DET_QUIET;
              detect_active_o <= 1'b0;
            end else if (rx_det_result_i == ALL_LANES) begin
              state               <= DET_DONE;
              lane_detect_o       <= rx_det_result_i;
              lane_detect_valid_o <= 1'b1;
            end else begin
              state <= DET_RETRY;
              mask1 <= rx_det_result_i;
            end
          end else if (pass_timeout) begin
            state           <= DET_QUIET;
            rx_det_req_o    <= 1'b0;
            detect_active_o <= 1'b0;
          end
        end
        DET_RETRY: begin
          if (enter_act) begin
            state        <= DET_ACT2;
            rx_det_req_o <= 1'b1;
          end
        end
        DET_ACT2: begin
          if (req_done) begin
            rx_det_req_o <= 1'b0;
            if (final_mask != '0) begin
              state               <= DET_DONE;
              lane_detect_o       <= final_mask;
              lane_detect_valid_o <= 1'b1;
            end else begin
              state           <= DET_QUIET;
              detect_active_o <= 1'b0;
            end
          end else if (pass_timeout) begin
            state           <= DET_QUIET;
            rx_det_req_o    <= 1'b0;
            detect_active_o <= 1'b0;
          end
        end
        DET_DONE: state <= DET_DONE;
        default: begin
          state           <= DET_IDLE;
          rx_det_req_o    <= 1'b0;
          detect_active_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_detect_sequencer.sv
// Directed bench for rx_detect_sequencer with hand-computed expectations.
module tb_rx_detect_sequencer;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [3:0] eidle_exit;
  logic       det_req;
  logic       det_done;
  logic [3:0] det_result;
  logic       det_active;
  logic [3:0] lane_det;
  logic       lane_valid;

  int n_checks = 0;
  int n_errors = 0;
  int n;

  rx_detect_sequencer #(
    .NUM_LANES(4), .QUIET_CYCLES(16), .RETRY_CYCLES(16), .DET_TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .enable_i            (enable),
    .rx_eidle_exit_i     (eidle_exit),
    .rx_det_req_o        (det_req),
    .rx_det_done_i       (det_done),
    .rx_det_result_i     (det_result),
    .detect_active_o     (det_active),
    .lane_detect_o       (lane_det),
    .lane_detect_valid_o (lane_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles until req rises (or -1 after 40 cycles).
  task automatic wait_req_high(output int cnt);
    cnt = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (det_req) begin
        cnt = i;
        break;
      end
    end
  endtask

  // Cycles until req falls (or -1 after 40 cycles).
  task automatic wait_req_low(output int cnt);
    cnt = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (!det_req) begin
        cnt = i;
        break;
      end
    end
  endtask

  // One done pulse with the given result, sampled on the next edge.
  task automatic pulse_done(input logic [3:0] res);
    det_done   = 1'b1;
    det_result = res;
    tick();
    det_done   = 1'b0;
    det_result = 4'b0000;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; eidle_exit = 4'b0000;
    det_done = 1'b0; det_result = 4'b0000;
    tick(); tick();
    check("reset_req", det_req, 0);
    check("reset_active", det_active, 0);
    check("reset_valid", lane_valid, 0);
    rst_n = 1'b1;
    tick();
    check("idle_active", det_active, 0);

    // Full detect on first pass.
    enable = 1'b1;
    tick();
    check("quiet_active", det_active, 0);
    wait_req_high(n);
    check("quiet_len", n, 16);
    check("act1_active", det_active, 1);
    tick();
    pulse_done(4'b1111);
    check("full_valid", lane_valid, 1);
    check("full_mask", lane_det, 15);
    check("full_req", det_req, 0);
    tick(); tick();
    check("done_hold_mask", lane_det, 15);

    // Drop enable in DONE, then restart.
    enable = 1'b0;
    tick();
    check("dis_done_valid", lane_valid, 0);
    check("dis_done_mask", lane_det, 0);
    check("dis_done_active", det_active, 0);
    enable = 1'b1;
    tick();
    wait_req_high(n);
    check("requiet_len", n, 16);

    // Two-pass partial detect.
    pulse_done(4'b1011);
    check("retry_req", det_req, 0);
    check("retry_active", det_active, 1);
    check("retry_valid", lane_valid, 0);
    wait_req_high(n);
    check("retry_len", n, 16);
    pulse_done(4'b0011);
    check("pass2_valid", lane_valid, 1);
    check("pass2_mask", lane_det, 3);

    // Drop enable in RETRY.
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    wait_req_high(n);
    check("q3_len", n, 16);
    pulse_done(4'b0110);
    tick(); tick();
    enable = 1'b0;
    tick();
    check("dis_retry_active", det_active, 0);
    check("dis_retry_req", det_req, 0);
    check("dis_retry_mask", lane_det, 0);
    enable = 1'b1;
    tick();
    wait_req_high(n);
    check("q4_len", n, 16);

    // Empty first pass returns to QUIET; eidle exit cuts QUIET short.
    pulse_done(4'b0000);
    check("empty_active", det_active, 0);
    check("empty_req", det_req, 0);
    tick(); tick(); tick();
    eidle_exit = 4'b0100;
    tick();
    eidle_exit = 4'b0000;
    check("eidle_req", det_req, 1);
    check("eidle_active", det_active, 1);

    // No done: pass times out after 8 cycles.
    wait_req_low(n);
    check("timeout_len", n, 8);
    check("timeout_active", det_active, 0);
    pulse_done(4'b1111);
    check("stray_valid", lane_valid, 0);
    check("stray_active", det_active, 0);
    wait_req_high(n);
    check("q5_len", n, 15);

    // Done on the same cycle the pass timer hits zero: done wins.
    for (int i = 0; i < 7; i++) tick();
    check("edge_req", det_req, 1);
    pulse_done(4'b1111);
    check("edge_valid", lane_valid, 1);
    check("edge_mask", lane_det, 15);

    // Async reset mid-ACT1.
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    wait_req_high(n);
    check("q6_len", n, 16);
    tick();
    rst_n = 1'b0;
    #1;
    check("async_req", det_req, 0);
    check("async_active", det_active, 0);
    check("async_valid", lane_valid, 0);
    #1;
    rst_n = 1'b1;
    tick();
    check("post_rst_active", det_active, 0);
    wait_req_high(n);
    check("post_rst_len", n, 16);
    tick();
    pulse_done(4'b1111);
    check("post_rst_valid", lane_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
